// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : shift_sequencer
// Description : Multi-cycle XLEN-bit SLL/SRL/SRA built from one narrow shifter
//               stepping at most 2^STEP_BITS-1 positions per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_sequencer #(
  parameter int XLEN      = 32,
  parameter int STEP_BITS = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [XLEN-1:0]           req_val,
  input  logic [$clog2(XLEN)-1:0]   req_sham,
  input  logic                      req_right,
  input  logic                      req_arith,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [XLEN-1:0]           resp_data,
  output logic                      busy
);

  localparam int SH_W = $clog2(XLEN);
  localparam logic [SH_W-1:0] c_step_max = SH_W'((1 << STEP_BITS) - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  logic [XLEN-1:0]    r_acc;
  logic [SH_W-1:0]    r_rem;
  logic               r_right;
  logic               r_arith;

  logic [SH_W-1:0]    w_step;
  logic [SH_W-1:0]    w_rem_next;
  logic [XLEN-1:0]    w_shl;
  logic [XLEN-1:0]    w_shr;
  logic signed [XLEN-1:0] w_sra;
  logic [XLEN-1:0]    w_shifted;

  // Narrow step shifter: the step never exceeds c_step_max, so per-step sign
  // fill from acc[XLEN-1] composes into a single arithmetic shift of sham.
  assign w_step     = (r_rem > c_step_max) ? c_step_max : r_rem;
  assign w_rem_next = r_rem - w_step;
  assign w_shl      = r_acc << w_step;
  assign w_shr      = r_acc >> w_step;
  assign w_sra      = $signed(r_acc) >>> w_step;

  always_comb begin
    w_shifted = w_shl;
    if (r_right) begin
      w_shifted = r_arith ? XLEN'(w_sra) : w_shr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_rem   <= '0;
      r_right <= 1'b0;
      r_arith <= 1'b0;
    end else if (flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_acc   <= req_val;
            r_rem   <= req_sham;
            r_right <= req_right;
            r_arith <= req_arith & req_right;
            r_state <= (req_sham != '0) ? S_SHIFT : S_DONE;
          end
        end
        S_SHIFT: begin
          r_acc <= w_shifted;
          r_rem <= w_rem_next;
          if (w_rem_next == '0) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (resp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Handshake outputs depend on state alone to keep request/response paths cut.
  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_DONE);
  assign busy       = (r_state != S_IDLE);
  assign resp_data  = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_sequencer
// Description : Directed self-checking bench for shift_sequencer (STEP_BITS
//               3, 1 and 5 instances share one request stream).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        req_valid;
  logic [31:0] req_val;
  logic [4:0]  req_sham;
  logic        req_right;
  logic        req_arith;
  logic        resp_ready;

  logic        req_ready0, resp_valid0, busy0;
  logic [31:0] resp_data0;
  logic        req_ready1, resp_valid1, busy1;
  logic [31:0] resp_data1;
  logic        req_ready5, resp_valid5, busy5;
  logic [31:0] resp_data5;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  shift_sequencer #(.XLEN(32), .STEP_BITS(3)) dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready0), .req_val(req_val),
    .req_sham(req_sham), .req_right(req_right), .req_arith(req_arith),
    .resp_valid(resp_valid0), .resp_ready(resp_ready), .resp_data(resp_data0),
    .busy(busy0)
  );

  shift_sequencer #(.XLEN(32), .STEP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready1), .req_val(req_val),
    .req_sham(req_sham), .req_right(req_right), .req_arith(req_arith),
    .resp_valid(resp_valid1), .resp_ready(resp_ready), .resp_data(resp_data1),
    .busy(busy1)
  );

  shift_sequencer #(.XLEN(32), .STEP_BITS(5)) dut5 (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready5), .req_val(req_val),
    .req_sham(req_sham), .req_right(req_right), .req_arith(req_arith),
    .resp_valid(resp_valid5), .resp_ready(resp_ready), .resp_data(resp_data5),
    .busy(busy5)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] v, input logic [4:0] s, input logic r, input logic a);
    req_val   = v;
    req_sham  = s;
    req_right = r;
    req_arith = a;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  // Edges from the accept edge (counted as 1) until resp_valid on dut0 is seen.
  task automatic wait_resp(input int start, output int lat);
    lat = start;
    while (!resp_valid0 && lat < 60) begin
      tick();
      lat++;
    end
  endtask

  task automatic consume();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  function automatic logic [31:0] model(input logic [31:0] v, input logic [4:0] s,
                                        input logic r, input logic a);
    logic signed [31:0] sv;
    sv = v;
    if (!r)     return v << s;
    else if (a) return 32'(sv >>> s);
    else        return v >> s;
  endfunction

  initial begin
    int lat;
    int waited;
    logic [31:0] v, e;
    logic [4:0]  s;
    logic        r, a;

    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_val = '0; req_sham = '0;
    req_right = 1'b0; req_arith = 1'b0; resp_ready = 1'b0;
    tick();
    check("rst_resp_valid", 32'(resp_valid0), 32'd0);
    check("rst_resp_data",  resp_data0, 32'h0);
    check("rst_busy",       32'(busy0), 32'd0);
    check("rst_req_ready",  32'(req_ready0), 32'd1);
    rst = 1'b0;
    tick();

    // SLL by 5: one SHIFT cycle then DONE
    issue(32'h8000_0001, 5'd5, 1'b0, 1'b0);
    check("sll5_busy_shift", 32'(busy0), 32'd1);
    check("sll5_no_resp",    32'(resp_valid0), 32'd0);
    wait_resp(1, lat);
    check("sll5_latency", lat, 32'd2);
    check("sll5_data",    resp_data0, 32'h0000_0020);
    check("sll5_busy_done", 32'(busy0), 32'd1);
    consume();
    check("sll5_idle", 32'(req_ready0), 32'd1);

    // Full-width SRA/SRL: steps 7,7,7,7,3
    issue(32'h8000_0000, 5'd31, 1'b1, 1'b1);
    wait_resp(1, lat);
    check("sra31_latency", lat, 32'd6);
    check("sra31_data",    resp_data0, 32'hFFFF_FFFF);
    consume();
    issue(32'h8000_0000, 5'd31, 1'b1, 1'b0);
    wait_resp(1, lat);
    check("srl31_latency", lat, 32'd6);
    check("srl31_data",    resp_data0, 32'h0000_0001);
    consume();

    // Zero shift goes straight to DONE
    issue(32'hDEAD_BEEF, 5'd0, 1'b1, 1'b1);
    wait_resp(1, lat);
    check("sham0_latency", lat, 32'd1);
    check("sham0_data",    resp_data0, 32'hDEAD_BEEF);
    consume();

    // Backpressure in DONE with a pending request
    issue(32'h0000_0001, 5'd4, 1'b0, 1'b0);
    wait_resp(1, lat);
    req_val = 32'h0000_0003; req_sham = 5'd1; req_right = 1'b0; req_arith = 1'b0;
    req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("stall_resp_valid", 32'(resp_valid0), 32'd1);
      check("stall_resp_data",  resp_data0, 32'h0000_0010);
      check("stall_req_ready",  32'(req_ready0), 32'd0);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("release_idle_ready", 32'(req_ready0), 32'd1);
    check("release_no_resp",    32'(resp_valid0), 32'd0);
    tick();
    req_valid = 1'b0;
    check("reaccept_busy", 32'(busy0), 32'd1);
    wait_resp(1, lat);
    check("reaccept_latency", lat, 32'd2);
    check("reaccept_data",    resp_data0, 32'h0000_0006);
    consume();

    // Flush in the second SHIFT cycle, with a competing request
    issue(32'hFFFF_FFFF, 5'd20, 1'b1, 1'b0);
    tick();
    flush = 1'b1;
    req_val = 32'h1234_5678; req_sham = 5'd3; req_valid = 1'b1;
    tick();
    flush = 1'b0; req_valid = 1'b0;
    check("flush_idle",    32'(busy0), 32'd0);
    check("flush_no_resp", 32'(resp_valid0), 32'd0);
    tick();
    check("flush_req_not_taken", 32'(busy0), 32'd0);
    tick();
    check("flush_still_no_resp", 32'(resp_valid0), 32'd0);
    issue(32'hF000_000F, 5'd20, 1'b1, 1'b0);
    wait_resp(1, lat);
    check("srl20_latency", lat, 32'd4);
    check("srl20_data",    resp_data0, 32'h0000_0F00);
    consume();

    // Asynchronous reset in the middle of SHIFT
    issue(32'h0000_0001, 5'd31, 1'b0, 1'b0);
    tick();
    #1 rst = 1'b1;
    #1;
    check("arst_busy",       32'(busy0), 32'd0);
    check("arst_resp_valid", 32'(resp_valid0), 32'd0);
    check("arst_resp_data",  resp_data0, 32'h0);
    check("arst_req_ready",  32'(req_ready0), 32'd1);
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("arst_no_resp_after", 32'(resp_valid0), 32'd0);

    // Random sweep across all three step widths with consumer stalls
    for (int n = 0; n < 30; n++) begin
      v = $urandom;
      s = 5'($urandom_range(0, 31));
      r = 1'($urandom_range(0, 1));
      a = 1'($urandom_range(0, 1));
      e = model(v, s, r, a);
      issue(v, s, r, a);
      waited = 0;
      while (!(resp_valid0 && resp_valid1 && resp_valid5) && waited < 60) begin
        tick();
        waited++;
      end
      check("sweep_all_valid", 32'(resp_valid0 & resp_valid1 & resp_valid5), 32'd1);
      check("sweep_data_sb3", resp_data0, e);
      check("sweep_data_sb1", resp_data1, e);
      check("sweep_data_sb5", resp_data5, e);
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) tick();
      check("sweep_hold_sb3", resp_data0, e);
      consume();
      check("sweep_idle", 32'(req_ready0 & req_ready1 & req_ready5), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
